irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Interrupt arbiter for the single-cycle MIPS core. It collects up to NSRC peripheral interrupt sources and latches their rising edges as pending events. It arbitrates them by fixed priority and drives the single `irq` input of the core controller, holding it until the core has entered kernel mode. Software controls it through four memory-mapped words on the data bus: pending, mask, in-service/EOI and global enable.

## Interface
- `NSRC`, 4: number of interrupt sources, 1..8; index 0 has the highest priority.
- `BASE`, 32'h4000_0020: byte address of register 0; registers sit at BASE+0, +4, +8 and +C.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `src` input NSRC: interrupt sources, already synchronous to `clk`; a rising edge is one event.
- `kernel` input 1: core PC bit 31; 1 means the core is in the handler or kernel code.
- `addr` input 32: data bus byte address.
- `wdata` input 32: data bus write data.
- `mem_wr` input 1: data bus write strobe.
- `mem_rd` input 1: data bus read strobe.
- `rdata` output 32: read data; combinational.
- `irq` output 1: interrupt request to the core controller; registered.
- `irq_id` output 3: index of the requested or in-service source; registered.

## Operation
- Register map (sel = `addr` equals BASE+offset, word aligned):
  - +0 PEND: read returns the pending bits. Writing a 1 clears that bit (W1C).
  - +4 MASK: read/write, NSRC bits. 1 = enabled.
  - +8 ISR: read returns {28'b0, active, `irq_id`}; active=1 only in state SERV. Any write is an EOI.
  - +C CTRL: bit0 = global enable (GEN); read/write.
  - Unused upper bits read as 0.
- Edge detection: `prev` <= `src` every cycle. The event vector is `src & ~prev`, and each event sets its PEND bit.
- Eligible vector = PEND & MASK & {NSRC{GEN}}. The winner is the lowest set index.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if eligible≠0 and `kernel`=0, go to REQ. In the same edge, latch the winner into `irq_id` and set `irq`=1.
  - REQ: `irq` stays 1 and `irq_id` is frozen; a higher-priority arrival does not preempt.
    - If `kernel`=1: go to SERV, set `irq`=0, and clear PEND[`irq_id`].
    - Else if PEND[`irq_id`] is cleared by a W1C this cycle: go to IDLE, set `irq`=0.
  - SERV: no new request. An EOI write returns to IDLE. Leaving `kernel` alone does not end service.
- No nesting; at most one request is outstanding.
- `rdata` is 0 when `mem_rd`=0 or `addr` matches no register.

## Timing
- Reset values: PEND=0, MASK=0, GEN=0, state=IDLE, `irq`=0, `irq_id`=0, `prev`=all ones.
  - With `prev` at all ones, sources that are already high at reset release raise no event.
- Latency from a `src` rising edge (cycle 0) to `irq`=1 is 2 edges: PEND sets at edge 1; `irq` rises at edge 2, given eligible and `kernel`=0.
- Reaching SERV or leaving REQ drops `irq` at the next edge.
- An EOI write in cycle n gives state IDLE at edge n+1. A new `irq` comes no earlier than edge n+2.
- Simultaneous event and W1C on the same bit: the set wins, so the new event is kept.
- An event on the in-service source while in SERV re-pends that source. It is serviced after the EOI.
- Clearing PEND in REQ is covered above. Changing MASK or GEN in REQ does not withdraw the request.
- EOI written in IDLE or REQ is ignored.
- Writes to MASK, CTRL or PEND take effect at the next edge. Arbitration uses register values from the current cycle.
- `reset` mid-request: `irq`=0 at the next edge, and all pending events are discarded.

## Test plan
- Reset and idle:
  - Stimulus: hold `src`=4'b1111 through reset. Then write MASK=F and CTRL=1.
  - Required: PEND reads 0 and `irq` stays 0; `rdata` at BASE+8 reads 0.
- Single request:
  - Stimulus: MASK=F, GEN=1, `kernel`=0; pulse `src[2]` at cycle 0.
  - Required: PEND=4 after edge 1; `irq`=1 and `irq_id`=2 after edge 2.
  - Then raise `kernel`: `irq`=0 and PEND=0 next edge, ISR reads 32'h0000_000A. An EOI write leads to IDLE.
- Priority:
  - Stimulus: pulse `src[3]` and `src[1]` in the same cycle.
  - Required: `irq_id`=1 first. After its EOI, with `kernel`=0, `irq_id`=3 two edges later.
- Masking and W1C:
  - Stimulus: MASK=4'b1110, then pulse `src[0]`.
  - Required: PEND=1 and no `irq`. Writing PEND=1 clears it (reads 0).
  - Stimulus: in REQ for source 2, write PEND=4.
  - Required: state returns to IDLE and `irq`=0 next edge.
- Set/clear collision and re-pend:
  - Stimulus: in SERV on source 0, pulse `src[0]` in the same cycle as a W1C of bit 0.
  - Required: PEND[0]=1. The EOI is followed by a new request with `irq_id`=0.
- Kernel gating:
  - Stimulus: `kernel`=1 while PEND is eligible.
  - Required: `irq` stays 0. It asserts 1 edge after `kernel` falls.

Source files
------------

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: latches source rising edges as pending events,
// raises one request to the core and holds it until kernel entry, then waits for EOI.
module irq_arbiter #(
    parameter int unsigned NSRC = 4,
    parameter logic [31:0] BASE = 32'h4000_0020
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            kernel,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            mem_wr,
    input  logic            mem_rd,
    output logic [31:0]     rdata,
    output logic            irq,
    output logic [2:0]      irq_id
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] prev_q, prev_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            gen_q, gen_d;
    logic            irq_q, irq_d;
    logic [2:0]      irq_id_q, irq_id_d;

    logic            sel_pend, sel_mask, sel_isr, sel_ctrl;
    logic [NSRC-1:0] evt, eligible, id_onehot, w1c, svc_clr;
    logic [2:0]      winner;
    logic            w1c_hit, eoi;

    assign sel_pend = (addr == BASE);
    assign sel_mask = (addr == BASE + 32'd4);
    assign sel_isr  = (addr == BASE + 32'd8);
    assign sel_ctrl = (addr == BASE + 32'd12);

    assign evt      = src & ~prev_q;
    assign eligible = pend_q & mask_q & {NSRC{gen_q}};
    assign w1c      = (mem_wr && sel_pend) ? wdata[NSRC-1:0] : {NSRC{1'b0}};
    assign eoi      = mem_wr && sel_isr;
    // A W1C only withdraws the request when no new event on that source re-sets it.
    assign w1c_hit  = |(w1c & id_onehot & ~evt);

    always_comb begin
        id_onehot = {NSRC{1'b0}};
        winner    = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            id_onehot[i] = (irq_id_q == 3'(i));
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end else begin
                winner = winner;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= {NSRC{1'b1}};
            pend_q   <= {NSRC{1'b0}};
            mask_q   <= {NSRC{1'b0}};
            gen_q    <= 1'b0;
            irq_q    <= 1'b0;
            irq_id_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            gen_q    <= gen_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((eligible != {NSRC{1'b0}}) && !kernel) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (kernel) begin
                    state_d = SERV;
                end else if (w1c_hit) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            SERV: begin
                if (eoi) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        svc_clr  = {NSRC{1'b0}};
        case (state_q)
            IDLE: begin
                if ((eligible != {NSRC{1'b0}}) && !kernel) begin
                    irq_d    = 1'b1;
                    irq_id_d = winner;
                end else begin
                    irq_d    = 1'b0;
                end
            end
            REQ: begin
                if (kernel) begin
                    irq_d   = 1'b0;
                    svc_clr = id_onehot;
                end else if (w1c_hit) begin
                    irq_d   = 1'b0;
                end else begin
                    irq_d   = 1'b1;
                end
            end
            SERV:    irq_d = 1'b0;
            default: irq_d = 1'b0;
        endcase
    end

    // New events win over W1C and service clears on the same bit.
    always_comb begin
        prev_d = src;
        pend_d = (pend_q & ~w1c & ~svc_clr) | evt;
        if (mem_wr && sel_mask) begin
            mask_d = wdata[NSRC-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (mem_wr && sel_ctrl) begin
            gen_d = wdata[0];
        end else begin
            gen_d = gen_q;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (!mem_rd) begin
            rdata = 32'd0;
        end else if (sel_pend) begin
            rdata = {{(32 - NSRC){1'b0}}, pend_q};
        end else if (sel_mask) begin
            rdata = {{(32 - NSRC){1'b0}}, mask_q};
        end else if (sel_isr) begin
            rdata = {28'd0, (state_q == SERV), irq_id_q};
        end else if (sel_ctrl) begin
            rdata = {31'd0, gen_q};
        end else begin
            rdata = 32'd0;
        end
    end

    assign irq    = irq_q;
    assign irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter with hand-computed expectations.
module tb_irq_arbiter;

    localparam logic [31:0] A_PEND = 32'h4000_0020;
    localparam logic [31:0] A_MASK = 32'h4000_0024;
    localparam logic [31:0] A_ISR  = 32'h4000_0028;
    localparam logic [31:0] A_CTRL = 32'h4000_002C;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src;
    logic        kernel;
    logic [31:0] addr, wdata, rdata;
    logic        mem_wr, mem_rd;
    logic        irq;
    logic [2:0]  irq_id;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    irq_arbiter #(.NSRC(4), .BASE(32'h4000_0020)) dut (
        .clk(clk), .reset(reset), .src(src), .kernel(kernel),
        .addr(addr), .wdata(wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .rdata(rdata), .irq(irq), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; mem_rd = 1'b1;
        #1;
        d = rdata;
        mem_rd = 1'b0; addr = 32'd0;
        #1;
    endtask

    // Source high for one cycle: pending at the edge that ends the pulse.
    task automatic pulse_src(input logic [3:0] b);
        src = src | b;
        tick();
        src = src & ~b;
    endtask

    task automatic check_irq(input string tag, input logic exp_irq, input logic [2:0] exp_id);
        check_eq({tag, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
        check_eq({tag, "_id"}, {29'd0, irq_id}, {29'd0, exp_id});
    endtask

    initial begin
        reset = 1'b1; src = 4'hF; kernel = 1'b0;
        addr = 32'd0; wdata = 32'd0; mem_wr = 1'b0; mem_rd = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_irq("rst", 1'b0, 3'd0);
        tick();
        bus_read(A_PEND, rd); check_eq("rst_pend", rd, 32'd0);
        bus_write(A_MASK, 32'hF);
        bus_write(A_CTRL, 32'h1);
        tick(); tick();
        check_eq("idle_irq", {31'd0, irq}, 32'd0);
        bus_read(A_PEND, rd); check_eq("idle_pend", rd, 32'd0);
        bus_read(A_ISR, rd);  check_eq("idle_isr", rd, 32'd0);
        bus_read(A_MASK, rd); check_eq("mask_rd", rd, 32'hF);
        bus_read(A_CTRL, rd); check_eq("ctrl_rd", rd, 32'h1);
        src = 4'h0;
        tick();
        bus_read(A_PEND, rd); check_eq("fall_pend", rd, 32'd0);

        // single request on source 2
        pulse_src(4'b0100);
        bus_read(A_PEND, rd); check_eq("s_pend", rd, 32'h4);
        check_eq("s_irq_e1", {31'd0, irq}, 32'd0);
        tick();
        check_irq("s_e2", 1'b1, 3'd2);
        kernel = 1'b1;
        tick();
        check_irq("s_serv", 1'b0, 3'd2);
        bus_read(A_PEND, rd); check_eq("s_pend_clr", rd, 32'd0);
        bus_read(A_ISR, rd);  check_eq("s_isr", rd, 32'hA);
        kernel = 1'b0;
        tick();
        bus_read(A_ISR, rd);  check_eq("s_isr_hold", rd, 32'hA);
        bus_write(A_ISR, 32'd0);
        bus_read(A_ISR, rd);  check_eq("s_eoi", rd, 32'h2);

        // priority: sources 3 and 1 together
        pulse_src(4'b1010);
        bus_read(A_PEND, rd); check_eq("p_pend", rd, 32'hA);
        tick();
        check_irq("p_first", 1'b1, 3'd1);
        pulse_src(4'b0001);
        check_irq("p_nopreempt", 1'b1, 3'd1);
        kernel = 1'b1;
        tick();
        kernel = 1'b0;
        bus_read(A_PEND, rd); check_eq("p_pend2", rd, 32'h9);
        bus_write(A_PEND, 32'h1);
        bus_write(A_ISR, 32'd0);
        check_eq("p_eoi_irq", {31'd0, irq}, 32'd0);
        tick();
        check_irq("p_second", 1'b1, 3'd3);
        kernel = 1'b1;
        tick();
        kernel = 1'b0;
        bus_write(A_ISR, 32'd0);

        // masking and W1C
        bus_write(A_MASK, 32'hE);
        pulse_src(4'b0001);
        bus_read(A_PEND, rd); check_eq("m_pend", rd, 32'h1);
        tick();
        check_eq("m_irq", {31'd0, irq}, 32'd0);
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, rd); check_eq("m_w1c", rd, 32'd0);
        bus_write(A_MASK, 32'hF);
        pulse_src(4'b0100);
        tick();
        check_irq("m_req", 1'b1, 3'd2);
        bus_write(A_PEND, 32'h4);
        check_eq("m_withdraw", {31'd0, irq}, 32'd0);
        bus_read(A_ISR, rd); check_eq("m_isr", rd, 32'h2);
        tick();
        check_eq("m_idle", {31'd0, irq}, 32'd0);

        // collision in SERV on source 0
        pulse_src(4'b0001);
        tick();
        check_irq("c_req", 1'b1, 3'd0);
        kernel = 1'b1;
        tick();
        kernel = 1'b0;
        bus_read(A_ISR, rd); check_eq("c_serv", rd, 32'h8);
        src = 4'b0001; addr = A_PEND; wdata = 32'h1; mem_wr = 1'b1;
        tick();
        src = 4'b0000; mem_wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        bus_read(A_PEND, rd); check_eq("c_pend", rd, 32'h1);
        check_eq("c_noirq", {31'd0, irq}, 32'd0);
        bus_write(A_ISR, 32'd0);
        tick();
        check_irq("c_repend", 1'b1, 3'd0);
        kernel = 1'b1;
        tick();
        kernel = 1'b0;
        bus_write(A_ISR, 32'd0);

        // kernel gating
        kernel = 1'b1;
        pulse_src(4'b0010);
        tick(); tick();
        check_eq("k_gate", {31'd0, irq}, 32'd0);
        kernel = 1'b0;
        tick();
        check_irq("k_release", 1'b1, 3'd1);

        // reset mid-request
        pulse_src(4'b1000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_irq("r_irq", 1'b0, 3'd0);
        bus_read(A_PEND, rd); check_eq("r_pend", rd, 32'd0);
        bus_read(A_MASK, rd); check_eq("r_mask", rd, 32'd0);
        bus_read(A_PEND + 32'h10, rd); check_eq("unmapped", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
